// File: rtl/gf180mcu_as_sc_mcu7t3v3_dfr_pipe.sv
// Enabled, scannable, resettable register pipeline: delays D/D_VALID by DEPTH enabled edges.
// One serial scan chain runs through every flop, data bits of a stage first, then its valid bit.
module gf180mcu_as_sc_mcu7t3v3_dfr_pipe #(
    parameter int unsigned          WIDTH       = 8,
    parameter int unsigned          DEPTH       = 2,
    parameter logic [WIDTH-1:0]     RESET_VALUE = '0
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             VPW,
    input  logic             VNW,
    input  logic             VDD,
    input  logic             VSS,
    input  logic [WIDTH-1:0] D,
    input  logic             D_VALID,
    input  logic             EN,
    input  logic             SCLR,
    input  logic             SE,
    input  logic             SI,
    output logic [WIDTH-1:0] Q,
    output logic             Q_VALID,
    output logic             SO
);
    localparam int unsigned L = DEPTH * (WIDTH + 1);

    // Stage k holds {v[k], s[k]}; flattening the packed array yields the scan-chain order.
    logic [DEPTH-1:0][WIDTH:0] st_q;
    logic [DEPTH-1:0][WIDTH:0] st_d;
    logic [L-1:0]              chain;

    logic unused_bias;
    assign unused_bias = &{VPW, VNW, VDD, VSS};

    assign chain = st_q;

    always_comb begin
        st_d = st_q;
        if (SE) begin
            st_d = {chain[L-2:0], SI};
        end else if (SCLR) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                st_d[k] = {1'b0, RESET_VALUE};
            end
        end else if (EN) begin
            st_d[0] = {D_VALID, D};
            for (int unsigned k = 1; k < DEPTH; k++) begin
                st_d[k] = st_q[k-1];
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                st_q[k] <= {1'b0, RESET_VALUE};
            end
        end else begin
            st_q <= st_d;
        end
    end

    assign Q       = st_q[DEPTH-1][WIDTH-1:0];
    assign Q_VALID = st_q[DEPTH-1][WIDTH];
    assign SO      = st_q[DEPTH-1][WIDTH];

endmodule
